sum_arbiter: RTL and testbench

Shares one signed adder datapath (instantiates the team's `sum` unit) between two requesters using a round-robin arbiter with a valid/ready handshake. Accepted operations are registered into a single-entry output slot with result, carry and zero flags, and a requester ID. Downstream applies backpressure through out_ready. Sits between the operand sources and the ALU result bus.

---
 rtl/sum_arbiter.sv | 129 ++++++++++++
 tb/tb_sum_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/sum_arbiter.sv
// Two-requester round-robin front end for a shared signed adder.
// The winner's sum, flags and ID sit in a one-entry output slot until downstream accepts it.

module sum #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH:0]   result,
  output logic                  carry,
  output logic                  zero
);
  // Sign-extend both operands by one bit so the sum cannot overflow.
  assign result = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
  assign carry  = a[DATA_WIDTH-1] & b[DATA_WIDTH-1];
  assign zero   = (result == '0);
endmodule

module sum_arbiter #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  input  logic [DATA_WIDTH-1:0]  req0_a,
  input  logic [DATA_WIDTH-1:0]  req0_b,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [DATA_WIDTH-1:0]  req1_a,
  input  logic [DATA_WIDTH-1:0]  req1_b,
  output logic                   req1_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH:0]    out_result,
  output logic                   out_carry,
  output logic                   out_zero,
  output logic                   out_id,
  output logic [COUNT_WIDTH-1:0] count0,
  output logic [COUNT_WIDTH-1:0] count1
);
  typedef enum logic {EMPTY, FULL} slot_state_t;

  slot_state_t             state_reg, state_next;
  logic                    last_grant_reg;
  logic [DATA_WIDTH:0]     result_reg;
  logic                    carry_reg, zero_reg, id_reg;
  logic [COUNT_WIDTH-1:0]  count_reg [2];

  logic [1:0]              req_valid;
  logic [1:0]              ready_vec;
  logic                    grant_idx;
  logic                    slot_free;
  logic                    handshake;
  logic [DATA_WIDTH-1:0]   op_a, op_b;
  logic [DATA_WIDTH:0]     sum_result;
  logic                    sum_carry, sum_zero;

  assign req_valid = {req1_valid, req0_valid};

  // Arbitration and slot next-state. Ready is only raised towards a valid winner,
  // so a ready always means a handshake.
  always_comb begin
    state_next = state_reg;
    grant_idx  = 1'b0;
    ready_vec  = 2'b00;
    slot_free  = (state_reg == EMPTY) || out_ready;
    if (!rst && slot_free) begin
      if (req_valid == 2'b11) grant_idx = ~last_grant_reg;
      else                    grant_idx = req_valid[1];
      ready_vec = req_valid & (grant_idx ? 2'b10 : 2'b01);
    end
    if (|ready_vec)                          state_next = FULL;
    else if (state_reg == FULL && out_ready) state_next = EMPTY;
  end

  assign handshake = |ready_vec;
  assign op_a      = grant_idx ? req1_a : req0_a;
  assign op_b      = grant_idx ? req1_b : req0_b;

  sum #(.DATA_WIDTH(DATA_WIDTH)) u_sum (
    .a      (op_a),
    .b      (op_b),
    .result (sum_result),
    .carry  (sum_carry),
    .zero   (sum_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= EMPTY;
    else     state_reg <= state_next;
  end

  // Data outputs only move on a handshake; a drain without refill leaves them as they were.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= 1'b1;
      result_reg     <= '0;
      carry_reg      <= 1'b0;
      zero_reg       <= 1'b0;
      id_reg         <= 1'b0;
    end else if (handshake) begin
      last_grant_reg <= grant_idx;
      result_reg     <= sum_result;
      carry_reg      <= sum_carry;
      zero_reg       <= sum_zero;
      id_reg         <= grant_idx;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_count
      always_ff @(posedge clk) begin
        if (rst)               count_reg[gi] <= '0;
        else if (ready_vec[gi]) count_reg[gi] <= count_reg[gi] + 1'b1;
      end
    end
  endgenerate

  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];
  assign out_valid  = (state_reg == FULL);
  assign out_result = result_reg;
  assign out_carry  = carry_reg;
  assign out_zero   = zero_reg;
  assign out_id     = id_reg;
  assign count0     = count_reg[0];
  assign count1     = count_reg[1];
endmodule

// File: tb/tb_sum_arbiter.sv
// Directed bench for sum_arbiter: an independent arbitration model predicts handshakes,
// and a scoreboard queue holds the expected result until the slot hands it downstream.

module tb_sum_arbiter;
  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic          req0_ready, req1_ready;
  logic          out_valid, out_ready;
  logic [DW:0]   out_result;
  logic          out_carry, out_zero, out_id;
  logic [CW-1:0] count0, count1;

  sum_arbiter #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carry(out_carry), .out_zero(out_zero), .out_id(out_id),
    .count0(count0), .count1(count1)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state: {result[8:0], carry, zero, id}
  logic [11:0]   sb_q[$];
  logic          m_full, m_last;
  logic [CW-1:0] m_cnt0, m_cnt1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] expect_entry(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                               input logic id);
    logic signed [DW:0] s;
    s = $signed(a) + $signed(b);
    return {s, (a[DW-1] & b[DW-1]), (s == 0), id};
  endfunction

  // One clock cycle: drive, check at the falling edge, update the model, advance.
  task automatic cycle(input string tag, input logic v0, input logic [DW-1:0] a0,
                       input logic [DW-1:0] b0, input logic v1, input logic [DW-1:0] a1,
                       input logic [DW-1:0] b1, input logic ordy);
    logic free, g, r0, r1;
    rst = 1'b0;
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    out_ready = ordy;
    @(negedge clk);
    free = !m_full || ordy;
    g  = (v0 && v1) ? ~m_last : v1;
    r0 = free && v0 && (g == 1'b0);
    r1 = free && v1 && (g == 1'b1);
    chk({tag, "_ready0"}, 32'(req0_ready), 32'(r0));
    chk({tag, "_ready1"}, 32'(req1_ready), 32'(r1));
    chk({tag, "_valid"}, 32'(out_valid), 32'(m_full));
    chk({tag, "_count0"}, 32'(count0), 32'(m_cnt0));
    chk({tag, "_count1"}, 32'(count1), 32'(m_cnt1));
    if (m_full) begin
      if (sb_q.size() == 0) begin
        chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
      end else begin
        chk({tag, "_slot"}, 32'({out_result, out_carry, out_zero, out_id}), 32'(sb_q[0]));
        if (ordy) void'(sb_q.pop_front());
      end
    end
    if (r0 || r1) begin
      sb_q.push_back(r1 ? expect_entry(a1, b1, 1'b1) : expect_entry(a0, b0, 1'b0));
      m_last = r1;
      if (r0) m_cnt0++;
      else    m_cnt1++;
      m_full = 1'b1;
    end else if (ordy) begin
      m_full = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input string tag, input logic v0, input logic v1);
    rst = 1'b1;
    req0_valid = v0; req0_a = 8'd9; req0_b = 8'd9;
    req1_valid = v1; req1_a = 8'd7; req1_b = 8'd7;
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_rst_ready0"}, 32'(req0_ready), 32'd0);
    chk({tag, "_rst_ready1"}, 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_full = 1'b0; m_last = 1'b1; m_cnt0 = '0; m_cnt1 = '0;
    sb_q.delete();
    chk({tag, "_rst_state"},
        32'({out_valid, out_result, out_carry, out_zero, out_id, count0, count1}), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; out_ready = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    m_full = 0; m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
    @(posedge clk); #1;
    do_reset("init", 1'b0, 1'b0);

    // -128 + -128
    cycle("neg", 1, 8'h80, 8'h80, 0, 0, 0, 1);
    chk("neg_result", 32'({out_result, out_carry, out_zero, out_id}), 32'({9'h100, 1'b1, 1'b0, 1'b0}));
    cycle("neg_drain", 0, 0, 0, 0, 0, 0, 1);

    // 5 + -5 from requester 1
    cycle("zero", 0, 0, 0, 1, 8'd5, 8'hFB, 1);
    chk("zero_result", 32'({out_result, out_carry, out_zero, out_id}), 32'({9'h000, 1'b0, 1'b1, 1'b1}));
    cycle("zero_drain", 0, 0, 0, 0, 0, 0, 1);

    // Contention: requester 1 won last, so this run starts with requester 0.
    for (int i = 0; i < 6; i++) begin
      cycle("cont", 1, 8'(i), 8'(2 * i), 1, 8'(100 + i), 8'hF0, 1);
      chk("cont_id", 32'(out_id), 32'(i % 2));
    end
    cycle("cont_drain", 0, 0, 0, 0, 0, 0, 1);
    chk("cont_counts", 32'({count0, count1}), 32'({4'd4, 4'd4}));

    // Backpressure: 127 + 1 held while downstream stalls.
    cycle("bp_load", 1, 8'd127, 8'd1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      cycle("bp_hold", 1, 8'd3, 8'd4, 0, 0, 0, 0);
      chk("bp_result", 32'(out_result), 32'h080);
    end
    cycle("bp_release", 1, 8'd3, 8'd4, 0, 0, 0, 1);
    chk("bp_next", 32'(out_result), 32'h007);
    cycle("bp_drain", 0, 0, 0, 0, 0, 0, 1);

    // Reset while full with requester 1 waiting; last winner was requester 0.
    cycle("mid_load", 1, 8'd10, 8'd20, 0, 0, 0, 0);
    cycle("mid_hold", 0, 0, 0, 1, 8'd1, 8'd1, 0);
    do_reset("mid", 1'b0, 1'b1);
    cycle("post_rst", 1, 8'd1, 8'd2, 1, 8'd3, 8'd4, 1);
    chk("post_rst_id", 32'(out_id), 32'd0);
    cycle("post_drain", 0, 0, 0, 0, 0, 0, 1);

    // Counter wrap on a 4-bit counter.
    do_reset("wrap", 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) cycle("wrap", 1, 8'(i), 8'd1, 0, 0, 0, 1);
    cycle("wrap_drain", 0, 0, 0, 0, 0, 0, 1);
    chk("wrap_count0", 32'(count0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
